reg_status_ckpt: RTL and testbench
==================================

# reg_status_ckpt

Parametrised architectural register file and rename-status table with branch checkpoints. It sits between decoder, ROB and issue logic. It returns each source operand's value, or the ROB entry it waits on, through `NREAD` read ports. On a mispredict it restores the rename map from a saved checkpoint, so a full pipeline clear is no longer required.

## Interface
Parameters:
- `XLEN`, 32, data width
- `NREG`, 32, architectural registers; index width `RB = $clog2(NREG)`; reg 0 hardwired to zero
- `ROB_BIT`, 3, ROB entry index width
- `NREAD`, 2, combinational read ports
- `NCKPT`, 4, checkpoint slots (power of two); `CB = $clog2(NCKPT)`

Ports (port `i` of a port group occupies slice `[i*W +: W]`):
- `clk_in` in 1: the single clock
- `rst_in` in 1: synchronous, active-low reset
- `rdy_in` in 1: when low, all state holds and no handshake is accepted
- `rd_id` in NREAD*RB: source register per read port
- `rd_val` out NREAD*XLEN: operand value
- `rd_has_dep` out NREAD: operand still pending in the ROB
- `rd_dep` out NREAD*ROB_BIT: ROB entry the operand waits on
- `rob_qry_entry` out NREAD*ROB_BIT: ROB lookup address, equal to the map entry of `rd_id`
- `rob_qry_ready` in NREAD: ROB entry has a result
- `rob_qry_val` in NREAD*XLEN: ROB result
- `commit_valid` in 1, `commit_rd` in RB, `commit_data` in XLEN, `commit_rob` in ROB_BIT: commit port
- `issue_valid` in 1, `issue_rd` in RB, `issue_rob` in ROB_BIT: rename (issue) port
- `ckpt_save` in 1: take a snapshot this cycle
- `ckpt_save_id` out CB: slot that a save would use (current tail)
- `ckpt_full` out 1: all slots are in use
- `ckpt_release` in 1: free the oldest slot (its branch committed correctly)
- `ckpt_restore` in 1, `ckpt_restore_id` in CB: mispredict recovery
- `flush` in 1: full clear (exception or unrecoverable case)

## Operation
State:
- `regs[NREG]`
- `dirty[NREG]`
- `map[NREG]` (ROB entries)
- per checkpoint slot: `ck_dirty`, `ck_map`, valid bit
- head and tail pointers of width CB, plus a count of width CB+1

Read port `i` (combinational, reflects state before this cycle's issue):
- `rd_id==0`: value 0, no dependency.
- Register not dirty: returns `regs`.
- Register dirty and a same-cycle commit has `commit_rd==rd_id` and `commit_rob==map[rd_id]`: returns `commit_data`, no dependency.
- Register dirty and `rob_qry_ready`: returns `rob_qry_val`, no dependency.
- Otherwise: `rd_has_dep=1`, `rd_dep=map[rd_id]`, `rd_val=0`.

Commit (`commit_valid`, `commit_rd!=0`):
- `regs[rd] <= data`.
- If `map[rd]==commit_rob`, clear `dirty[rd]`.
- The same clear applies to every valid checkpoint whose `ck_map[rd]==commit_rob`.

Issue (`issue_valid`, `issue_rd!=0`):
- `dirty[rd] <= 1`, `map[rd] <= issue_rob`.
- When issue and commit hit the same register, issue wins.

Save (`ckpt_save`, `!ckpt_full`):
- The slot at tail captures the next-state map, i.e. after this cycle's commit and issue.
- Slot is marked valid; tail and count increment.
- A save while full is ignored and flagged with an assertion.

Release: head advances and count decrements. Release while empty is an assertion.

Restore:
- Live `dirty`/`map` load from slot `id`, with this cycle's commit clear applied.
- Slot `id` and every younger slot are invalidated; tail becomes `id`; count is recomputed from head to `id`.
- Issue and save in the same cycle are ignored.
- A same-cycle release is applied first. Restoring the slot being released is illegal and flagged with an assertion.

Flush:
- Clears all `dirty`, `map` and checkpoint valid bits; resets pointers.
- `regs` are kept.
- A commit in the same cycle still writes `regs`.

Priority: reset > `!rdy_in` > flush > restore > normal (commit, issue, save, release).

## Timing
- Reads: 0-cycle combinational.
- All updates become visible to reads on the next edge.
- `ckpt_full` and `ckpt_save_id` are registered-state derived and valid from the cycle after any update.
- Reset (`rst_in` low at an edge):
  - all `regs`, `dirty`, `map` and checkpoints are zero; pointers are 0;
  - `ckpt_full=0`, `ckpt_save_id=0`;
  - read outputs are value 0 with no dependency for all ids.
- Reset asserted mid-operation discards all checkpoints that cycle.
- Pointers wrap modulo `NCKPT`; full exactly when count equals `NCKPT`.

## Structure
- Shared package holds `XLEN`, `ROB_BIT`, `NREG` defaults and a snapshot struct (`dirty` vector plus map array).
- One sub-module, `ckpt_bank`: the slot storage, valid bits, pointers, and commit-clear across slots.
- The top level holds the live table, the read muxes and the priority logic.

## Test plan
- Reset, then read x0 and x5 → value 0 and no dependency on both ports; `ckpt_full=0`.
- Issue x5@ROB3; next cycle read x5 with ROB not ready → `has_dep=1`, `dep=3`. Commit x5=0x1234 from ROB3 → same-cycle read returns 0x1234 with no dependency; next cycle x5 is clean.
- Issue x5@3, then issue x5@6, then commit x5 from ROB3 → `regs[5]=commit_data` but x5 stays dirty with `dep=6`.
- Save (slot 0) with x7@2; issue x7@4; save (slot 1); restore slot 0 → x7 maps to 2, slot 1 is invalid, `ckpt_save_id=0`.
- Save with x9@1; commit x9 from ROB1; restore that slot → x9 is clean with value `commit_data`.
- Fill four slots → `ckpt_full=1`; a fifth save is ignored. Release one → `ckpt_full=0`, tail wraps to slot 0. Flush → all registers clean and counts zero. Hold `rdy_in` low during issue → no state change.

Source files
------------

// File: rtl/reg_status_ckpt_pkg.sv
// Shared sizes, rename-snapshot payload and the commit-clear helper used by the
// live rename table and by every checkpoint slot.
package reg_status_ckpt_pkg;

  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_NREG    = 32;
  localparam int unsigned DEF_ROB_BIT = 3;
  localparam int unsigned DEF_RB      = $clog2(DEF_NREG);

  typedef logic [DEF_ROB_BIT-1:0] rob_id_t;
  typedef logic [DEF_RB-1:0]      reg_id_t;

  typedef struct packed {
    logic [DEF_NREG-1:0]    dirty;
    rob_id_t [DEF_NREG-1:0] map;
  } snap_t;

  // A commit only cleans a register whose mapping still names the committing entry.
  function automatic snap_t commit_clear(input snap_t s, input logic en,
                                         input reg_id_t rd, input rob_id_t rob);
    snap_t r;
    r = s;
    if (en && (s.map[rd] == rob)) r.dirty[rd] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/reg_status_ckpt_ckpt_bank.sv
// Circular bank of rename snapshots taken at branches; tracks head/tail/count
// and keeps every live snapshot coherent with commits.
module ckpt_bank
  import reg_status_ckpt_pkg::*;
#(
  parameter int unsigned NCKPT = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush,
  input  logic                      cm_en,
  input  reg_id_t                   commit_rd,
  input  rob_id_t                   commit_rob,
  input  logic                      save,
  input  snap_t                     save_snap,
  input  logic                      rel,
  input  logic                      restore,
  input  logic [$clog2(NCKPT)-1:0]  restore_id,
  output logic [$clog2(NCKPT)-1:0]  save_id,
  output logic                      full,
  output snap_t                     rest_snap
);

  localparam int unsigned CB = $clog2(NCKPT);

  snap_t            slot_q [NCKPT];
  logic [NCKPT-1:0] valid_q, valid_d;
  logic [CB-1:0]    head_q, head_d, tail_q, tail_d, rel_head;
  logic [CB:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             do_save, do_rel;

  assign save_id   = tail_q;
  assign full      = full_q;
  assign rest_snap = slot_q[restore_id];

  // Pointer/valid next state; a restore sees the same-cycle release first.
  always_comb begin : next_state
    valid_d  = valid_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    do_save  = save && !full_q && !flush && !restore;
    do_rel   = rel && (count_q != '0) && !flush;
    rel_head = do_rel ? head_q + CB'(1) : head_q;
    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (restore) begin
      if (do_rel) valid_d[head_q] = 1'b0;
      for (int unsigned k = 0; k < NCKPT; k++) begin
        if ((CB'(k) - rel_head) >= (restore_id - rel_head)) valid_d[k] = 1'b0;
      end
      head_d  = rel_head;
      tail_d  = restore_id;
      count_d = {1'b0, CB'(restore_id - rel_head)};
    end else begin
      if (do_rel) begin
        valid_d[head_q] = 1'b0;
        head_d          = rel_head;
      end
      if (do_save) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + CB'(1);
      end
      count_d = count_q + (CB+1)'(do_save) - (CB+1)'(do_rel);
    end
    full_d = (count_d == (CB+1)'(NCKPT));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int unsigned k = 0; k < NCKPT; k++) slot_q[k] <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (rdy_in) begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      for (int unsigned k = 0; k < NCKPT; k++)
        slot_q[k] <= commit_clear(slot_q[k], cm_en && valid_q[k], commit_rd, commit_rob);
      if (do_save) slot_q[tail_q] <= save_snap;
    end
  end

  // Illegal checkpoint sequencing from the branch unit.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !flush) begin
      assert (!(save && full_q && !restore)) else $error("ckpt_bank: save while full ignored");
      assert (!(rel && (count_q == '0))) else $error("ckpt_bank: release while empty");
      assert (!(restore && rel && (restore_id == head_q)))
        else $error("ckpt_bank: restore of the slot being released");
    end
  end

endmodule

// File: rtl/reg_status_ckpt.sv
// Architectural register file plus rename-status table with branch checkpoints;
// combinational operand read ports with commit and ROB bypass.
module reg_status_ckpt
  import reg_status_ckpt_pkg::*;
#(
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned NREG    = DEF_NREG,     // snapshot type is sized by the package
  parameter int unsigned ROB_BIT = DEF_ROB_BIT,  // snapshot type is sized by the package
  parameter int unsigned NREAD   = 2,
  parameter int unsigned NCKPT   = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic [NREAD*$clog2(NREG)-1:0] rd_id,
  output logic [NREAD*XLEN-1:0]         rd_val,
  output logic [NREAD-1:0]              rd_has_dep,
  output logic [NREAD*ROB_BIT-1:0]      rd_dep,
  output logic [NREAD*ROB_BIT-1:0]      rob_qry_entry,
  input  logic [NREAD-1:0]              rob_qry_ready,
  input  logic [NREAD*XLEN-1:0]         rob_qry_val,
  input  logic                          commit_valid,
  input  logic [$clog2(NREG)-1:0]       commit_rd,
  input  logic [XLEN-1:0]               commit_data,
  input  logic [ROB_BIT-1:0]            commit_rob,
  input  logic                          issue_valid,
  input  logic [$clog2(NREG)-1:0]       issue_rd,
  input  logic [ROB_BIT-1:0]            issue_rob,
  input  logic                          ckpt_save,
  output logic [$clog2(NCKPT)-1:0]      ckpt_save_id,
  output logic                          ckpt_full,
  input  logic                          ckpt_release,
  input  logic                          ckpt_restore,
  input  logic [$clog2(NCKPT)-1:0]      ckpt_restore_id,
  input  logic                          flush
);

  localparam int unsigned RB = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  snap_t           live_q, live_d, live_norm, rest_snap;
  logic            cm_en, is_en;
  logic [RB-1:0]   id;
  rob_id_t         ent;

  assign cm_en = commit_valid && (commit_rd != '0);
  assign is_en = issue_valid && (issue_rd != '0);

  ckpt_bank #(.NCKPT(NCKPT)) u_bank (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush      (flush),
    .cm_en      (cm_en),
    .commit_rd  (commit_rd),
    .commit_rob (commit_rob),
    .save       (ckpt_save),
    .save_snap  (live_norm),
    .rel        (ckpt_release),
    .restore    (ckpt_restore),
    .restore_id (ckpt_restore_id),
    .save_id    (ckpt_save_id),
    .full       (ckpt_full),
    .rest_snap  (rest_snap)
  );

  // Issue overrides a same-register commit; live_norm is also what a save captures.
  always_comb begin : live_next
    live_norm = commit_clear(live_q, cm_en, commit_rd, commit_rob);
    if (is_en) begin
      live_norm.dirty[issue_rd] = 1'b1;
      live_norm.map[issue_rd]   = issue_rob;
    end
    live_d = live_norm;
    if (flush)             live_d = '0;
    else if (ckpt_restore) live_d = commit_clear(rest_snap, cm_en, commit_rd, commit_rob);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      live_q <= '0;
      for (int unsigned k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (rdy_in) begin
      live_q <= live_d;
      if (cm_en) regs[commit_rd] <= commit_data;
    end
  end

  // Operand read: x0, clean value, commit bypass, ROB bypass, else dependency.
  always_comb begin : read_ports
    rd_val        = '0;
    rd_has_dep    = '0;
    rd_dep        = '0;
    rob_qry_entry = '0;
    id            = '0;
    ent           = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      id  = rd_id[i*RB +: RB];
      ent = live_q.map[id];
      rob_qry_entry[i*ROB_BIT +: ROB_BIT] = ent;
      if (id != '0) begin
        if (!live_q.dirty[id])
          rd_val[i*XLEN +: XLEN] = regs[id];
        else if (cm_en && (commit_rd == id) && (commit_rob == ent))
          rd_val[i*XLEN +: XLEN] = commit_data;
        else if (rob_qry_ready[i])
          rd_val[i*XLEN +: XLEN] = rob_qry_val[i*XLEN +: XLEN];
        else begin
          rd_has_dep[i]                = 1'b1;
          rd_dep[i*ROB_BIT +: ROB_BIT] = ent;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_status_ckpt.sv
// Directed + constrained-random bench for reg_status_ckpt against an in-bench
// architectural model of the register file, rename map and checkpoint queue.
module tb_reg_status_ckpt;

  localparam int XLEN = 32, NREG = 32, RBW = 5, ROBW = 3, NREAD = 2, NCKPT = 4, CBW = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                  rst_in, rdy_in;
  logic [NREAD*RBW-1:0]  rd_id;
  logic [NREAD*XLEN-1:0] rd_val;
  logic [NREAD-1:0]      rd_has_dep;
  logic [NREAD*ROBW-1:0] rd_dep, rob_qry_entry;
  logic [NREAD-1:0]      rob_qry_ready;
  logic [NREAD*XLEN-1:0] rob_qry_val;
  logic                  commit_valid, issue_valid;
  logic [RBW-1:0]        commit_rd, issue_rd;
  logic [XLEN-1:0]       commit_data;
  logic [ROBW-1:0]       commit_rob, issue_rob;
  logic                  ckpt_save, ckpt_full, ckpt_release, ckpt_restore, flush;
  logic [CBW-1:0]        ckpt_save_id, ckpt_restore_id;

  reg_status_ckpt #(.XLEN(XLEN), .NREG(NREG), .ROB_BIT(ROBW), .NREAD(NREAD), .NCKPT(NCKPT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rd_id(rd_id), .rd_val(rd_val), .rd_has_dep(rd_has_dep), .rd_dep(rd_dep),
    .rob_qry_entry(rob_qry_entry), .rob_qry_ready(rob_qry_ready), .rob_qry_val(rob_qry_val),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_rob(commit_rob), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rob(issue_rob), .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_full(ckpt_full), .ckpt_release(ckpt_release), .ckpt_restore(ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id), .flush(flush)
  );

  int n_checks = 0, n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural model: live table plus a queue of snapshots kept in ring slots.
  logic [31:0] m_regs [NREG];
  bit          m_dirty [NREG];
  logic [2:0]  m_map [NREG];
  bit          ck_v [NCKPT];
  bit          ck_d [NCKPT][NREG];
  logic [2:0]  ck_m [NCKPT][NREG];
  int          m_head, m_tail, m_count;

  always @(posedge clk_in) begin
    bit cm, is, was_full;
    int id, younger, cnt0;
    if (!rst_in) begin
      for (int r = 0; r < NREG; r++) begin m_regs[r] = 0; m_dirty[r] = 0; m_map[r] = 0; end
      for (int s = 0; s < NCKPT; s++) ck_v[s] = 0;
      m_head = 0; m_tail = 0; m_count = 0;
    end else if (rdy_in) begin
      cm = commit_valid && (commit_rd != 0);
      is = issue_valid && (issue_rd != 0);
      if (cm) m_regs[commit_rd] = commit_data;
      if (cm) for (int s = 0; s < NCKPT; s++)
        if (ck_v[s] && ck_m[s][commit_rd] == commit_rob) ck_d[s][commit_rd] = 0;
      if (flush) begin
        for (int r = 0; r < NREG; r++) begin m_dirty[r] = 0; m_map[r] = 0; end
        for (int s = 0; s < NCKPT; s++) ck_v[s] = 0;
        m_head = 0; m_tail = 0; m_count = 0;
      end else if (ckpt_restore) begin
        if (ckpt_release) begin ck_v[m_head] = 0; m_head = (m_head + 1) % NCKPT; m_count--; end
        id = int'(ckpt_restore_id);
        for (int r = 0; r < NREG; r++) begin m_dirty[r] = ck_d[id][r]; m_map[r] = ck_m[id][r]; end
        younger = m_count - ((id - m_head + NCKPT) % NCKPT);
        for (int j = 0; j < younger; j++) ck_v[(id + j) % NCKPT] = 0;
        m_count = (id - m_head + NCKPT) % NCKPT;
        m_tail  = id;
      end else begin
        if (cm && m_map[commit_rd] == commit_rob) m_dirty[commit_rd] = 0;
        if (is) begin m_dirty[issue_rd] = 1; m_map[issue_rd] = issue_rob; end
        was_full = (m_count == NCKPT);
        cnt0     = m_count;
        if (ckpt_save && !was_full) begin
          for (int r = 0; r < NREG; r++) begin ck_d[m_tail][r] = m_dirty[r]; ck_m[m_tail][r] = m_map[r]; end
          ck_v[m_tail] = 1; m_tail = (m_tail + 1) % NCKPT; m_count++;
        end
        if (ckpt_release && cnt0 > 0) begin
          ck_v[m_head] = 0; m_head = (m_head + 1) % NCKPT; m_count--;
        end
      end
    end
  end

  // Every cycle: all read ports and checkpoint status against the model.
  always @(negedge clk_in) begin
    if (chk_en) begin
      for (int i = 0; i < NREAD; i++) begin
        logic [4:0]  id;
        logic [31:0] ev;
        logic        ed;
        logic [2:0]  edp;
        id = rd_id[i*RBW +: RBW];
        ev = 0; ed = 0; edp = 0;
        if (id != 0) begin
          if (!m_dirty[id]) ev = m_regs[id];
          else if (commit_valid && commit_rd == id && commit_rob == m_map[id]) ev = commit_data;
          else if (rob_qry_ready[i]) ev = rob_qry_val[i*XLEN +: XLEN];
          else begin ed = 1; edp = m_map[id]; end
        end
        check($sformatf("model rd_val[%0d] x%0d", i, id), rd_val[i*XLEN +: XLEN], ev);
        check($sformatf("model rd_has_dep[%0d] x%0d", i, id), 32'(rd_has_dep[i]), 32'(ed));
        check($sformatf("model rd_dep[%0d] x%0d", i, id), 32'(rd_dep[i*ROBW +: ROBW]), 32'(edp));
        check($sformatf("model rob_qry_entry[%0d] x%0d", i, id),
              32'(rob_qry_entry[i*ROBW +: ROBW]), 32'(m_map[id]));
      end
      check("model ckpt_full", 32'(ckpt_full), 32'(m_count == NCKPT));
      check("model ckpt_save_id", 32'(ckpt_save_id), 32'(m_tail));
    end
  end

  task automatic tick(); @(posedge clk_in); #1; endtask

  task automatic idle();
    commit_valid = 0; issue_valid = 0; ckpt_save = 0; ckpt_release = 0;
    ckpt_restore = 0; flush = 0; rob_qry_ready = 0;
  endtask

  task automatic setrd(input int a, input int b); rd_id = {5'(b), 5'(a)}; endtask
  task automatic do_issue(input int r, input int rob);
    issue_valid = 1; issue_rd = 5'(r); issue_rob = 3'(rob);
  endtask
  task automatic do_commit(input int r, input logic [31:0] d, input int rob);
    commit_valid = 1; commit_rd = 5'(r); commit_data = d; commit_rob = 3'(rob);
  endtask

  initial begin
    int off;
    rst_in = 0; rdy_in = 1; idle(); setrd(0, 0);
    commit_rd = 0; commit_data = 0; commit_rob = 0; issue_rd = 0; issue_rob = 0;
    ckpt_restore_id = 0; rob_qry_val = 0;
    tick(); chk_en = 1; tick(); rst_in = 1;

    setrd(0, 5); @(negedge clk_in);
    check("reset x0 val", rd_val[31:0], 32'h0);
    check("reset x5 val", rd_val[63:32], 32'h0);
    check("reset has_dep", 32'(rd_has_dep), 32'h0);
    check("reset ckpt_full", 32'(ckpt_full), 32'h0);
    check("reset save_id", 32'(ckpt_save_id), 32'h0);

    do_issue(5, 3); tick(); idle(); setrd(5, 0); @(negedge clk_in);
    check("x5 pending has_dep", 32'(rd_has_dep[0]), 32'h1);
    check("x5 pending dep", 32'(rd_dep[2:0]), 32'h3);
    check("x5 qry entry", 32'(rob_qry_entry[2:0]), 32'h3);

    do_commit(5, 32'h1234, 3); @(negedge clk_in);
    check("x5 commit bypass val", rd_val[31:0], 32'h1234);
    check("x5 commit bypass dep", 32'(rd_has_dep[0]), 32'h0);
    tick(); idle(); @(negedge clk_in);
    check("x5 clean val", rd_val[31:0], 32'h1234);

    do_issue(6, 2); tick(); idle(); setrd(0, 6);
    rob_qry_ready = 2'b10; rob_qry_val = {32'hBEEF, 32'h0}; @(negedge clk_in);
    check("x6 rob bypass val", rd_val[63:32], 32'hBEEF);
    check("x6 rob bypass dep", 32'(rd_has_dep[1]), 32'h0);
    check("x6 qry entry", 32'(rob_qry_entry[5:3]), 32'h2);
    idle();

    do_issue(5, 3); tick(); do_issue(5, 6); tick(); idle();
    do_commit(5, 32'hAAAA, 3); tick(); idle(); setrd(5, 0); @(negedge clk_in);
    check("x5 stale commit has_dep", 32'(rd_has_dep[0]), 32'h1);
    check("x5 stale commit dep", 32'(rd_dep[2:0]), 32'h6);
    do_commit(5, 32'hBBBB, 6); tick(); idle(); @(negedge clk_in);
    check("x5 second commit val", rd_val[31:0], 32'hBBBB);

    do_issue(7, 2); ckpt_save = 1; tick(); idle(); @(negedge clk_in);
    check("save slot0 tail", 32'(ckpt_save_id), 32'h1);
    do_issue(7, 4); tick(); idle(); ckpt_save = 1; tick(); idle(); setrd(7, 0); @(negedge clk_in);
    check("save slot1 tail", 32'(ckpt_save_id), 32'h2);
    check("x7 at rob4", 32'(rd_dep[2:0]), 32'h4);
    ckpt_restore = 1; ckpt_restore_id = 0; tick(); idle(); @(negedge clk_in);
    check("restore x7 dep", 32'(rd_dep[2:0]), 32'h2);
    check("restore x7 has_dep", 32'(rd_has_dep[0]), 32'h1);
    check("restore save_id", 32'(ckpt_save_id), 32'h0);

    do_issue(9, 1); ckpt_save = 1; tick(); idle();
    do_commit(9, 32'h9999, 1); tick(); idle();
    ckpt_restore = 1; ckpt_restore_id = 0; tick(); idle(); setrd(9, 0); @(negedge clk_in);
    check("restore x9 val", rd_val[31:0], 32'h9999);
    check("restore x9 has_dep", 32'(rd_has_dep[0]), 32'h0);

    ckpt_save = 1; repeat (4) tick(); idle(); @(negedge clk_in);
    check("four saves full", 32'(ckpt_full), 32'h1);
    check("four saves tail wrap", 32'(ckpt_save_id), 32'h0);
    ckpt_release = 1; tick(); idle(); @(negedge clk_in);
    check("release full", 32'(ckpt_full), 32'h0);
    ckpt_save = 1; tick(); idle(); @(negedge clk_in);
    check("wrap save full", 32'(ckpt_full), 32'h1);
    check("wrap save tail", 32'(ckpt_save_id), 32'h1);
    ckpt_restore = 1; ckpt_restore_id = 3; ckpt_release = 1; tick(); idle(); @(negedge clk_in);
    check("restore+release full", 32'(ckpt_full), 32'h0);
    check("restore+release tail", 32'(ckpt_save_id), 32'h3);

    do_issue(3, 5); tick(); idle();
    flush = 1; do_commit(3, 32'h3333, 2); tick(); idle(); setrd(3, 7); @(negedge clk_in);
    check("flush x3 val", rd_val[31:0], 32'h3333);
    check("flush has_dep", 32'(rd_has_dep), 32'h0);
    check("flush save_id", 32'(ckpt_save_id), 32'h0);

    rdy_in = 0; do_issue(10, 2); ckpt_save = 1; tick(); idle(); rdy_in = 1; setrd(10, 0);
    @(negedge clk_in);
    check("rdy low no issue", 32'(rd_has_dep[0]), 32'h0);
    check("rdy low no save", 32'(ckpt_save_id), 32'h0);

    for (int n = 0; n < 300; n++) begin
      idle();
      rdy_in = ($urandom_range(0, 7) != 0);
      setrd($urandom_range(0, 7), $urandom_range(0, 7));
      rob_qry_ready = 2'($urandom_range(0, 3));
      rob_qry_val = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        commit_valid = 1; commit_rd = 5'($urandom_range(0, 7)); commit_data = $urandom;
        commit_rob = ($urandom_range(0, 1) == 1) ? m_map[commit_rd] : 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 1) == 1) do_issue($urandom_range(0, 7), $urandom_range(0, 7));
      if (m_count < NCKPT && $urandom_range(0, 2) == 0) ckpt_save = 1;
      if (m_count > 0 && $urandom_range(0, 4) == 0) ckpt_release = 1;
      if (m_count > 0 && $urandom_range(0, 7) == 0) begin
        off = $urandom_range(0, m_count - 1);
        ckpt_restore = 1; ckpt_restore_id = 2'((m_head + off) % NCKPT);
        if (off == 0) ckpt_release = 0;
      end
      if ($urandom_range(0, 39) == 0) flush = 1;
      tick();
    end

    idle(); rdy_in = 1; do_issue(4, 1); ckpt_save = 1; tick();
    rst_in = 0; do_issue(5, 2); tick(); idle(); setrd(3, 5); @(negedge clk_in);
    check("mid reset full", 32'(ckpt_full), 32'h0);
    check("mid reset save_id", 32'(ckpt_save_id), 32'h0);
    check("mid reset x3 val", rd_val[31:0], 32'h0);
    check("mid reset x5 has_dep", 32'(rd_has_dep[1]), 32'h0);
    rst_in = 1; tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
